lut_sweep_eval: RTL and testbench

- Parametrised exhaustive evaluator for a boolean function with N_IN inputs and N_OUT outputs.
- The function is held in a software-loadable truth table (LUT).
- On start, the block sweeps every input vector from 0 to 2^N_IN-1 and streams {vector, result} over a valid/ready interface.
- It keeps a per-output count of ones, used as a signature for self-checking combinational lab designs.

---
 rtl/lut_sweep_eval.sv | 125 ++++++++++++
 tb/tb_lut_sweep_eval.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lut_sweep_eval.sv
// lut_sweep_eval: exhaustive truth-table sweeper with per-output ones counters.
// A loadable LUT (2^N_IN rows x N_OUT bits) is swept from index 0 to
// 2^N_IN-1 on start, streaming {vector, result} over valid/ready.
// Optional macro SWEEP_GRAY_EN: emit vectors in Gray order instead of binary.
module lut_sweep_eval #(
   parameter  int unsigned N_IN  = 3,
   parameter  int unsigned N_OUT = 2,
   localparam int unsigned CW    = N_IN + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic [N_IN-1:0]       cfg_addr,
   input  logic [N_OUT-1:0]      cfg_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [N_IN-1:0]       vec_out,
   output logic [N_OUT-1:0]      res_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [N_OUT*CW-1:0]   ones_cnt
);

   localparam int unsigned DEPTH = 1 << N_IN;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [N_IN-1:0]        idx_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   valid_q;
   logic [N_OUT*CW-1:0]    cnt_q;
   logic [N_OUT-1:0]       tab_q [DEPTH];

   logic [N_OUT*CW-1:0]    cnt_d;
   logic [N_IN-1:0]        idx_d;
   logic [N_IN-1:0]        vec_d;
   logic                   last_d;
   logic                   accept_d;

   // Index-to-vector mapping, table read and counter/index next values
   always_comb begin
`ifdef SWEEP_GRAY_EN
      vec_d = idx_q ^ (idx_q >> 1);
`else
      vec_d = idx_q;
`endif
      accept_d = valid_q & res_ready;
      last_d   = (idx_q == {N_IN{1'b1}});
      idx_d    = idx_q + 1'b1;
      cnt_d    = cnt_q;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + CW'(tab_q[vec_d][k]);
      end
   end

   // Sweep FSM: table load in IDLE, beat streaming in RUN, one-cycle DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tab_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               // Write lands at this edge, so a simultaneous start sees it
               if (cfg_we) begin
                  tab_q[cfg_addr] <= cfg_data;
               end
               if (start) begin
                  state_q <= S_RUN;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (accept_d) begin
                  cnt_q <= cnt_d;
                  if (last_d) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign res_valid = valid_q;
   assign vec_out   = vec_d;
   assign res_out   = tab_q[vec_d];
   assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_lut_sweep_eval.sv
`timescale 1ns/1ps
module tb_lut_sweep_eval;

   logic       clk;
   logic       rst_n;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [1:0] cfg_data;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] vec_out;
   logic [1:0] res_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] ones_cnt;

   int unsigned chk_cnt  = 0;
   int unsigned pass_cnt = 0;
   int unsigned fail_cnt = 0;

   logic [1:0] exp_tab [8];

   lut_sweep_eval #(.N_IN(3), .N_OUT(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .vec_out  (vec_out),
      .res_out  (res_out),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .ones_cnt (ones_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_vec(input int i);
      logic [2:0] b;
      b = 3'(i);
`ifdef SWEEP_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   // Full sweep with res_ready high except an optional 3-cycle stall at stall_vec;
   // optionally pokes start and cfg_we during beat 3 (both must be ignored).
   task automatic run_sweep(input int stall_vec, input bit inject, input logic [7:0] exp_ones);
      logic [2:0] v;
      start     = 1'b1;
      res_ready = 1'b1;
      tick();
      start  = 1'b0;
      cfg_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v = exp_vec(i);
         chk("vec",   32'(vec_out),   32'(v));
         chk("res",   32'(res_out),   32'(exp_tab[v]));
         chk("valid", 32'(res_valid), 32'd1);
         chk("busy",  32'(busy),      32'd1);
         if (int'(v) == stall_vec) begin
            res_ready = 1'b0;
            repeat (3) begin
               tick();
               chk("stall_vec",   32'(vec_out),   32'(v));
               chk("stall_res",   32'(res_out),   32'(exp_tab[v]));
               chk("stall_valid", 32'(res_valid), 32'd1);
            end
            res_ready = 1'b1;
         end
         if (inject && i == 3) begin
            start    = 1'b1;
            cfg_we   = 1'b1;
            cfg_addr = 3'd1;
            cfg_data = 2'b11;
         end
         tick();
         start  = 1'b0;
         cfg_we = 1'b0;
      end
      chk("done_pulse", 32'(done),      32'd1);
      chk("done_busy",  32'(busy),      32'd0);
      chk("done_valid", 32'(res_valid), 32'd0);
      chk("ones",       32'(ones_cnt),  32'(exp_ones));
      tick();
      chk("done_drop",  32'(done),      32'd0);
      chk("idle_busy",  32'(busy),      32'd0);
      chk("ones_hold",  32'(ones_cnt),  32'(exp_ones));
      tick();
      chk("no_2nd_done", 32'(done),     32'd0);
   endtask

   initial begin
      logic [1:0] rows [8];
      rows = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      start     = 1'b0;
      res_ready = 1'b0;
      #12;
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_vec",   32'(vec_out),   32'd0);
      chk("rst_ones",  32'(ones_cnt),  32'd0);
      rst_n = 1'b1;
      tick();

      // Table load: bit0 ones = rows 0,2,5,7 -> 4; bit1 ones = rows 0,4,5,6,7 -> 5
      for (int r = 0; r < 8; r++) begin
         cfg_we   = 1'b1;
         cfg_addr = 3'(r);
         cfg_data = rows[r];
         exp_tab[r] = rows[r];
         tick();
      end
      cfg_we = 1'b0;
      chk("idle_after_load", 32'(busy), 32'd0);

      run_sweep(-1, 1'b0, 8'h54);
      run_sweep(2, 1'b0, 8'h54);
      run_sweep(-1, 1'b1, 8'h54);
      run_sweep(-1, 1'b0, 8'h54);

      // Asynchronous reset while vec=4 is on the bus
      start     = 1'b1;
      res_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (exp_vec(i) == 3'd4) break;
         tick();
      end
      chk("pre_rst_vec", 32'(vec_out), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_busy",  32'(busy),      32'd0);
      chk("mrst_valid", 32'(res_valid), 32'd0);
      chk("mrst_done",  32'(done),      32'd0);
      chk("mrst_ones",  32'(ones_cnt),  32'd0);
      chk("mrst_vec",   32'(vec_out),   32'd0);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      for (int r = 0; r < 8; r++) exp_tab[r] = 2'b00;
      run_sweep(-1, 1'b0, 8'h00);

      // Same-cycle write of row 0 and start: first beat must show the new value
      cfg_we   = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 2'b10;
      exp_tab[0] = 2'b10;
      run_sweep(-1, 1'b0, 8'h10);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
